fmau_booth_seq: RTL and testbench
=================================

# fmau_booth_seq

Iterative radix-4 Booth multiplier sequencer for the FMAU. It accepts one signed 25×25-bit operand pair over a valid/ready handshake. It then steps the 25-bit Booth digit encoder across the multiplier one digit per cycle and accumulates the partial products into a 50-bit signed product, which is held until the consumer accepts it. It sits between the FMAU issue logic and the mantissa alignment stage, serving small-area configurations that have no parallel compressor tree.

## Interface
- No parameters; widths are fixed (A, B: 25 bits; product: 50 bits; 13 Booth digits).
- `forever_cpuclk`  in  1  clock; all state updates on the rising edge
- `cpurst`  in  1  reset, synchronous, active-high
- `req_vld`  in  1  operand pair valid
- `req_rdy`  out  1  block can accept an operand pair; high only in IDLE
- `req_a`  in  25  multiplicand, two's complement
- `req_b`  in  25  multiplier, two's complement
- `flush`  in  1  abort the current operation and discard any held result
- `res_vld`  out  1  product valid; high only in DONE
- `res_rdy`  in  1  consumer accepts the product
- `res_prod`  out  50  signed product A×B
- `busy`  out  1  state is not IDLE

## Operation
- States:
  - IDLE: `req_rdy`=1. On `req_vld`: latch A, latch B sign-extended to 26 bits with B[-1]=0, clear acc, set cnt=0, go to CALC.
  - CALC: process digit `cnt`, then `cnt`+1. After the digit with cnt=12 is processed, go to DONE.
  - DONE: `res_vld`=1. On `res_rdy`, go to IDLE.
- Digit i uses code = {B[2i+1], B[2i], B[2i-1]}; for digit 12, B[25]=B[24].
- The encoder (`product` 25b, `sn`, `h` 2b) is instantiated once and driven with the latched A and the current code.
- Partial-product value = signed 26-bit {~sn, product} + h (unsigned 0..2). This equals d_i·A with d_i ∈ {−2,−1,0,+1,+2}.
- Accumulate: acc ← acc + (pp sign-extended to 50 bits) << 2i. All arithmetic is 50-bit modulo 2^50. The result is exact for every input, including −2^24 × −2^24.
- `res_prod` = acc. It is stable throughout DONE.
- `flush`: the state goes to IDLE on the next edge from any state; acc and cnt are cleared and no result is presented. `flush` has priority over `req_vld` and `res_rdy` in the same cycle. A request presented in the same cycle as `flush` is not accepted.
- `cpurst` high: all state and outputs go to reset values on the next edge, regardless of operation in progress.
- Reset values: state IDLE, `req_rdy`=1, `res_vld`=0, `res_prod`=0, `busy`=0, cnt=0.

## Timing
- Accepting edge E0 is the edge where `req_vld`&`req_rdy`.
- CALC spans N edges; `res_vld` is high from edge E0+N onward. N=13 without early termination.
- `res_vld` holds, with `res_prod` unchanged, until the edge where `res_rdy`=1. `res_vld` drops on that edge.
- The next request can be accepted no earlier than the edge after the result is accepted, since IDLE is re-entered first.
- Back-to-back throughput is one product per N+2 cycles.
- There are no combinational paths from `req_vld` or `res_rdy` to any output.

## Configuration
- `FMAU_BOOTH_SEQ_EARLY_TERM_EN` defined:
  - After processing digit i in CALC, if B[25:2i+1] are all equal, the remaining digits all encode 000 or 111 (zero). In that case the state goes to DONE instead of continuing.
  - This gives N = min over i of (i+1) satisfying that condition, in the range 1..13.
  - The product value is identical to the full run.
- Undefined: N=13 always, and no termination-detect logic is synthesized.

## Test plan
- A=3, B=5, `res_rdy`=1 → `res_vld` at E0+13 (macro off) or E0+2 (macro on); `res_prod`=50'd15; IDLE one edge later.
- A=25'h1FFFFFF (−1), B=25'h1FFFFFF → `res_prod`=50'd1; macro on: N=1.
- A=B=25'h1000000 (−2^24) → `res_prod`=50'h1_0000_0000_0000 (2^48); A=25'h0FFFFFF, B=25'h1000000 → `res_prod`=−(2^48−2^24), i.e. 50'h3_0000_0100_0000.
- Hold `res_rdy`=0 for 20 cycles after `res_vld` → `res_vld` and `res_prod` stable and `req_rdy`=0 throughout; raise `res_rdy` → `res_vld` drops the next edge; a new request is accepted the following edge.
- Assert `flush` at E0+5 alongside `req_vld`=1 → IDLE next edge, `res_vld` never rises, request not accepted; resubmit A=7, B=−3 → `res_prod`=−21 (50'h3_FFFF_FFFF_FFEB).
- Assert `cpurst` mid-CALC → all outputs at reset values the next edge; a following request A=2, B=2 yields 4.

Source files
------------

// File: rtl/fmau_booth_seq.sv
// fmau_booth_seq: iterative radix-4 Booth multiplier, signed 25x25 -> 50 bits.
// One Booth digit is retired per clock; the product is held in DONE until
// the consumer takes it.
// Optional build macro: FMAU_BOOTH_SEQ_EARLY_TERM_EN. When it is defined, CALC
// stops as soon as the remaining multiplier digits are all zero.

// Radix-4 Booth digit encoder.
// {~sn, product} + h is the signed partial product d*A, with d in {-2..+2}.
module fmau_booth_enc (
  input  logic [24:0] a,
  input  logic [2:0]  code,
  output logic [24:0] product,
  output logic        sn,
  output logic [1:0]  h
);

  // Select the magnitude (A or 2A) and invert it for negative digits;
  // h supplies the +1 that completes the two's complement.
  always_comb begin
    product = '0;
    sn      = 1'b1;
    h       = 2'd0;
    case (code)
      3'b001, 3'b010: begin
        product = a;
        sn      = ~a[24];
      end
      3'b011: begin
        product = {a[23:0], 1'b0};
        sn      = ~a[24];
      end
      3'b100: begin
        product = {~a[23:0], 1'b1};
        sn      = a[24];
        h       = 2'd1;
      end
      3'b101, 3'b110: begin
        product = ~a;
        sn      = a[24];
        h       = 2'd1;
      end
      default: begin
        product = '0;
        sn      = 1'b1;
        h       = 2'd0;
      end
    endcase
  end

endmodule

module fmau_booth_seq (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [24:0] req_a,
  input  logic [24:0] req_b,
  input  logic        flush,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic [49:0] res_prod,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [24:0] a_reg;
  // b_reg[j] holds multiplier bit j-1: bit 0 is the implicit B[-1]=0 and
  // bit 26 is the sign extension B[25].
  logic [26:0] b_reg;
  logic [49:0] acc_reg;
  logic [3:0]  cnt_reg;

  logic [2:0]  digit_code [16];
  logic [2:0]  code;
  logic [24:0] enc_product;
  logic        enc_sn;
  logic [1:0]  enc_h;
  logic [49:0] pp_ext;
  logic [49:0] pp_shift;
  logic        calc_last;

  // Overlapping 3-bit windows of the multiplier, one per Booth digit.
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_digit
      assign digit_code[gi] = b_reg[2*gi+2 : 2*gi];
    end
    for (genvar gi = 13; gi < 16; gi++) begin : g_digit_pad
      assign digit_code[gi] = 3'b000;
    end
  endgenerate

  assign code = digit_code[cnt_reg];

  fmau_booth_enc u_enc (
    .a       (a_reg),
    .code    (code),
    .product (enc_product),
    .sn      (enc_sn),
    .h       (enc_h)
  );

  // Sign-extend the 26-bit partial product before adding h so the
  // -2*(-2^24) corner does not wrap.
  assign pp_ext   = {{24{~enc_sn}}, ~enc_sn, enc_product} + {48'd0, enc_h};
  assign pp_shift = pp_ext << {cnt_reg, 1'b0};

`ifdef FMAU_BOOTH_SEQ_EARLY_TERM_EN
  // term_ok[i]: after digit i, every remaining window lies inside a run of
  // equal multiplier bits, so every later digit encodes to zero.
  logic [15:0] term_ok;
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_term
      assign term_ok[gi] = (&b_reg[26:2*gi+2]) | ~(|b_reg[26:2*gi+2]);
    end
  endgenerate
  assign term_ok[15:13] = 3'b111;
  assign calc_last = (cnt_reg == 4'd12) || term_ok[cnt_reg];
`else
  assign calc_last = (cnt_reg == 4'd12);
`endif

  // State register.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_next = state_reg;
    req_rdy    = 1'b0;
    res_vld    = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        req_rdy = 1'b1;
        busy    = 1'b0;
        if (req_vld) state_next = ST_CALC;
      end
      ST_CALC: begin
        if (calc_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        res_vld = 1'b1;
        if (res_rdy) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Operand capture, digit counter and product accumulation.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (flush) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_vld) begin
            a_reg   <= req_a;
            b_reg   <= {req_b[24], req_b, 1'b0};
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        end
        ST_CALC: begin
          acc_reg <= acc_reg + pp_shift;
          cnt_reg <= cnt_reg + 4'd1;
        end
        default: begin
          acc_reg <= acc_reg;
        end
      endcase
    end
  end

  assign res_prod = acc_reg;

endmodule

// File: tb/tb_fmau_booth_seq.sv
// Self-checking bench for fmau_booth_seq: directed corner cases plus random
// operands, with a queue-based scoreboard fed by the stimulus and drained by
// an independent output monitor.
module tb_fmau_booth_seq;

  logic        forever_cpuclk;
  logic        cpurst;
  logic        req_vld;
  logic        req_rdy;
  logic [24:0] req_a;
  logic [24:0] req_b;
  logic        flush;
  logic        res_vld;
  logic        res_rdy;
  logic [49:0] res_prod;
  logic        busy;

  fmau_booth_seq dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_a          (req_a),
    .req_b          (req_b),
    .flush          (flush),
    .res_vld        (res_vld),
    .res_rdy        (res_rdy),
    .res_prod       (res_prod),
    .busy           (busy)
  );

  typedef struct {
    logic [24:0] a;
    logic [24:0] b;
    logic [49:0] prod;
    int          n;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rnd    = 1'b0;

  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product: plain signed multiply, kept modulo 2^50.
  function automatic logic [49:0] ref_prod(input logic [24:0] a, input logic [24:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[49:0];
  endfunction

  // Reference latency: with early termination the run stops after the first
  // digit i for which B fits in a signed (2i+2)-bit number.
  function automatic int ref_n(input logic [24:0] b);
`ifdef FMAU_BOOTH_SEQ_EARLY_TERM_EN
    longint v;
    longint lim;
    v = longint'($signed(b));
    for (int i = 0; i < 13; i++) begin
      lim = longint'(1) << (2 * i + 1);
      if (v >= -lim && v < lim) return i + 1;
    end
    return 13;
`else
    if (b === 25'hx) return 0;
    return 13;
`endif
  endfunction

  // Present one request; must be called just after a falling edge.
  task automatic send(input logic [24:0] a, input logic [24:0] b, output int acc_cyc);
    exp_t e;
    bit   done;
    done    = 1'b0;
    acc_cyc = -1;
    req_a   = a;
    req_b   = b;
    req_vld = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (req_rdy) begin
        e.a       = a;
        e.b       = b;
        e.prod    = ref_prod(a, b);
        e.n       = ref_n(b);
        e.acc_cyc = cyc + 1;
        acc_cyc   = e.acc_cyc;
        sb.push_back(e);
        done = 1'b1;
        break;
      end
      @(posedge forever_cpuclk);
      #1;
      if (rnd) res_rdy = 1'($urandom_range(0, 1));
      @(negedge forever_cpuclk);
    end
    if (!done) chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge forever_cpuclk);
    #1;
    req_vld = 1'b0;
    if (rnd) res_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_vld();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge forever_cpuclk);
      if (res_vld) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("res_vld_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    bit empty;
    empty   = 1'b0;
    res_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge forever_cpuclk);
      if (sb.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    if (!empty) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge forever_cpuclk);
  endtask

  // Monitor: checks latency when res_vld rises, stability while it is held,
  // and the product on every accepted result.
  initial begin
    bit          prev_vld;
    logic [49:0] held;
    prev_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge forever_cpuclk);
      if (!cpurst && !flush) begin
        if (res_vld && !prev_vld) begin
          held = res_prod;
          if (sb.size() == 0) chk("unexpected_res_vld", 64'd1, 64'd0);
          else chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].n));
        end else if (res_vld && prev_vld) begin
          chk("prod_stable", 64'(res_prod), 64'(held));
        end
        if (res_vld && res_rdy) begin
          if (sb.size() == 0) begin
            chk("result_without_request", 64'd1, 64'd0);
          end else begin
            chk("res_prod", 64'(res_prod), 64'(sb[0].prod));
            $display("txn a=%h b=%h prod=%h expected=%h n=%0d", sb[0].a, sb[0].b,
                     res_prod, sb[0].prod, sb[0].n);
            void'(sb.pop_front());
          end
        end
      end
      prev_vld = res_vld;
    end
  end

  initial begin
    int          acc;
    int          r;
    int          vld_seen;
    logic [31:0] t;
    logic [24:0] ra;
    logic signed [24:0] rb;

    cpurst  = 1'b1;
    req_vld = 1'b0;
    req_a   = '0;
    req_b   = '0;
    flush   = 1'b0;
    res_rdy = 1'b0;
    repeat (3) @(posedge forever_cpuclk);
    #1;
    cpurst = 1'b0;
    @(negedge forever_cpuclk);
    chk("reset_req_rdy", 64'(req_rdy), 64'd1);
    chk("reset_res_vld", 64'(res_vld), 64'd0);
    chk("reset_res_prod", 64'(res_prod), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // 3 x 5, consumer always ready; IDLE is back one edge after DONE.
    res_rdy = 1'b1;
    send(25'd3, 25'd5, acc);
    wait_vld();
    @(negedge forever_cpuclk);
    chk("idle_after_accept_req_rdy", 64'(req_rdy), 64'd1);
    chk("idle_after_accept_res_vld", 64'(res_vld), 64'd0);

    // Sign corners.
    send(25'h1FFFFFF, 25'h1FFFFFF, acc);
    wait_done();
    send(25'h1000000, 25'h1000000, acc);
    wait_done();
    send(25'h0FFFFFF, 25'h1000000, acc);
    wait_done();
    chk("scoreboard_sanity", 64'(ref_prod(25'h0FFFFFF, 25'h1000000)), 64'h3_0000_0100_0000);

    // Back-pressure: result held for 20 cycles, then released.
    res_rdy = 1'b0;
    t = $urandom;
    send(t[24:0], 25'h0AAAAAA, acc);
    wait_vld();
    for (int k = 0; k < 20; k++) begin
      @(negedge forever_cpuclk);
      chk("hold_res_vld", 64'(res_vld), 64'd1);
      chk("hold_req_rdy", 64'(req_rdy), 64'd0);
    end
    @(posedge forever_cpuclk);
    #1;
    res_rdy = 1'b1;
    r = cyc;
    @(negedge forever_cpuclk);
    chk("release_res_vld_before_edge", 64'(res_vld), 64'd1);
    @(negedge forever_cpuclk);
    chk("release_res_vld_dropped", 64'(res_vld), 64'd0);
    chk("release_req_rdy", 64'(req_rdy), 64'd1);
    send(25'd11, 25'h1FFFFF3, acc);
    chk("next_accept_cycle", 64'(acc - r), 64'd2);
    wait_done();

    // Flush at E0+5 with a competing request.
    send(25'h0123456, 25'h0AAAAAA, acc);
    repeat (4) @(posedge forever_cpuclk);
    #1;
    flush   = 1'b1;
    req_vld = 1'b1;
    req_a   = 25'd9;
    req_b   = 25'd9;
    @(posedge forever_cpuclk);
    #1;
    flush   = 1'b0;
    req_vld = 1'b0;
    sb.delete();
    @(negedge forever_cpuclk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_req_rdy", 64'(req_rdy), 64'd1);
    chk("flush_res_vld", 64'(res_vld), 64'd0);
    vld_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge forever_cpuclk);
      if (res_vld) vld_seen++;
    end
    chk("flush_no_result", 64'(vld_seen), 64'd0);
    send(25'd7, 25'h1FFFFFD, acc);
    wait_done();

    // Reset in the middle of CALC.
    send(25'h1234567, 25'h0AAAAAA, acc);
    repeat (3) @(posedge forever_cpuclk);
    #1;
    cpurst = 1'b1;
    @(posedge forever_cpuclk);
    #1;
    cpurst = 1'b0;
    sb.delete();
    @(negedge forever_cpuclk);
    chk("midrst_req_rdy", 64'(req_rdy), 64'd1);
    chk("midrst_res_vld", 64'(res_vld), 64'd0);
    chk("midrst_res_prod", 64'(res_prod), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    send(25'd2, 25'd2, acc);
    wait_done();

    // Random operands with a randomly stalling consumer; the multiplier is
    // arithmetically shifted to cover every early-termination length.
    rnd = 1'b1;
    for (int n = 0; n < 40; n++) begin
      t  = $urandom;
      ra = t[24:0];
      t  = $urandom;
      rb = t[24:0];
      rb = rb >>> $urandom_range(0, 24);
      send(ra, rb, acc);
      repeat ($urandom_range(0, 2)) @(posedge forever_cpuclk);
      @(negedge forever_cpuclk);
    end
    rnd = 1'b0;
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
